hashcheck_driver: RTL and testbench

Synthesizable initiator for the hash checker's two-phase protocol (newrdy store / checkrdy query). It first streams a list of target NT hashes into the checker, then accepts candidate hashes with their candidate index from the MD4 pipeline, queries the checker one candidate at a time, and reports matching indices. It sits between the candidate generator/MD4 core and `hashchecker`, and is the only block that drives the checker's `newrdy`, `checkrdy` and `hash` inputs.

---
 rtl/hashcheck_driver_pkg.sv | 8 +
 rtl/hashcheck_driver.sv | 138 +++++++++++++
 tb/tb_hashcheck_driver.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hashcheck_driver_pkg.sv
// Shared constants for the hash checker interface: digest width and the
// length of the newrdy/checkrdy strobes the checker expects.
package hashcheck_driver_pkg;

    localparam int HASH_W    = 128;
    localparam int PULSE_LEN = 2;

endpackage

// File: rtl/hashcheck_driver.sv
// Initiator for the hash checker: streams target hashes in (newrdy), then
// queries candidate digests one at a time (checkrdy) and reports match indices.
module hashcheck_driver
    import hashcheck_driver_pkg::*;
#(
    parameter  int MAX_TARGETS = 16,
    parameter  int IDX_W       = 48,
    parameter  int TIMEOUT     = 1024,
    localparam int CNT_W       = $clog2(MAX_TARGETS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic [HASH_W-1:0] tgt_hash,
    input  logic              tgt_last,
    input  logic              cand_valid,
    output logic              cand_ready,
    input  logic [HASH_W-1:0] cand_hash,
    input  logic [IDX_W-1:0]  cand_index,
    output logic              newrdy,
    output logic              checkrdy,
    output logic [HASH_W-1:0] hash,
    input  logic              resultrdy,
    input  logic              matchfound,
    output logic              found_valid,
    output logic [IDX_W-1:0]  found_index,
    output logic [CNT_W-1:0]  loaded_count,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_TARGETS);
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, L_SETUP, L_P1, L_P2, L_GAP, C_SETUP, C_P1, C_P2, C_WAIT
    } state_t;

    state_t             state;
    logic               check_phase;
    logic               last_seen;
    logic [IDX_W-1:0]   idx_q;
    logic [WAIT_W-1:0]  wait_cnt;

    // Ready flags are registered, so they are set on the transition back into IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            check_phase  <= 1'b0;
            last_seen    <= 1'b0;
            tgt_ready    <= 1'b1;
            cand_ready   <= 1'b0;
            newrdy       <= 1'b0;
            checkrdy     <= 1'b0;
            hash         <= '0;
            found_valid  <= 1'b0;
            found_index  <= '0;
            loaded_count <= '0;
            overflow     <= 1'b0;
            timeout_err  <= 1'b0;
            idx_q        <= '0;
            wait_cnt     <= '0;
        end else begin
            found_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!check_phase && tgt_valid && tgt_ready) begin
                        if (loaded_count < MAX_CNT) begin
                            hash      <= tgt_hash;
                            last_seen <= tgt_last;
                            tgt_ready <= 1'b0;
                            state     <= L_SETUP;
                        end else begin
                            overflow <= 1'b1;
                            if (tgt_last) begin
                                check_phase <= 1'b1;
                                tgt_ready   <= 1'b0;
                                cand_ready  <= 1'b1;
                            end
                        end
                    end else if (check_phase && cand_valid && cand_ready) begin
                        hash       <= cand_hash;
                        idx_q      <= cand_index;
                        cand_ready <= 1'b0;
                        state      <= C_SETUP;
                    end
                end
                L_SETUP: begin
                    newrdy       <= 1'b1;
                    loaded_count <= loaded_count + 1'b1;
                    state        <= L_P1;
                end
                L_P1: state <= L_P2;
                L_P2: begin
                    newrdy <= 1'b0;
                    state  <= L_GAP;
                end
                L_GAP: begin
                    state <= IDLE;
                    if (last_seen) begin
                        check_phase <= 1'b1;
                        cand_ready  <= 1'b1;
                    end else begin
                        tgt_ready <= 1'b1;
                    end
                end
                C_SETUP: begin
                    checkrdy <= 1'b1;
                    state    <= C_P1;
                end
                C_P1: state <= C_P2;
                C_P2: begin
                    checkrdy <= 1'b0;
                    wait_cnt <= '0;
                    state    <= C_WAIT;
                end
                C_WAIT: begin
                    if (resultrdy) begin
                        found_valid <= matchfound;
                        if (matchfound) found_index <= idx_q;
                        cand_ready  <= 1'b1;
                        state       <= IDLE;
                    end else if (wait_cnt == WAIT_END) begin
                        timeout_err <= 1'b1;
                        cand_ready  <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hashcheck_driver.sv
// Scoreboard bench for hashcheck_driver against a behavioural checker with a
// 3-cycle result latency; a separate monitor pops expected match indices.
module tb_hashcheck_driver;
    import hashcheck_driver_pkg::*;

    localparam int MAXT = 3;
    localparam int IDXW = 48;
    localparam int TMO  = 8;
    localparam int LCW  = $clog2(MAXT + 1);

    localparam logic [127:0] T0 = 128'h0CB6948805F797BF2A82807973B89537;
    localparam logic [127:0] T1 = 128'h7454070F0339BBC993CB08EAF741513A;
    localparam logic [127:0] T2 = 128'h61FB34469B9989B01BE4E8630C52EED6;
    localparam logic [127:0] C6 = 128'h7CE21F17C0AEE7FB9CEBA532D0546AD6;
    localparam logic [127:0] HA = 128'h11111111222222223333333344444444;
    localparam logic [127:0] HB = 128'h55555555666666667777777788888888;
    localparam logic [127:0] HC = 128'h9999999AAAAAAAABBBBBBBBCCCCCCCC0;
    localparam logic [127:0] HD = 128'hDDDDDDDDEEEEEEEEFFFFFFFF00000001;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tgt_valid = 1'b0, tgt_ready, tgt_last = 1'b0;
    logic [127:0]      tgt_hash = '0;
    logic              cand_valid = 1'b0, cand_ready;
    logic [127:0]      cand_hash = '0;
    logic [IDXW-1:0]   cand_index = '0;
    logic              newrdy, checkrdy;
    logic [127:0]      hash;
    logic              resultrdy = 1'b0, matchfound = 1'b0;
    logic              found_valid;
    logic [IDXW-1:0]   found_index;
    logic [LCW-1:0]    loaded_count;
    logic              overflow, timeout_err;

    always #5 clk = ~clk;

    hashcheck_driver #(.MAX_TARGETS(MAXT), .IDX_W(IDXW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_hash(tgt_hash), .tgt_last(tgt_last),
        .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_hash(cand_hash),
        .cand_index(cand_index), .newrdy(newrdy), .checkrdy(checkrdy), .hash(hash),
        .resultrdy(resultrdy), .matchfound(matchfound), .found_valid(found_valid),
        .found_index(found_index), .loaded_count(loaded_count), .overflow(overflow),
        .timeout_err(timeout_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural checker: stores on newrdy rise, answers 3 cycles after checkrdy rise.
    logic [127:0] store[$];
    logic         nr_d = 1'b0, cr_d = 1'b0;
    int           lat = 0;
    bit           mute = 1'b0;
    logic [127:0] qhash = '0;

    function automatic logic in_store(input logic [127:0] h);
        foreach (store[i]) if (store[i] == h) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        nr_d       <= newrdy;
        cr_d       <= checkrdy;
        resultrdy  <= 1'b0;
        matchfound <= 1'b0;
        if (newrdy && !nr_d) store.push_back(hash);
        if (checkrdy && !cr_d) begin
            lat   <= 2;
            qhash <= hash;
        end else if (lat > 0) begin
            lat <= lat - 1;
            if (lat == 1 && !mute) begin
                resultrdy  <= 1'b1;
                matchfound <= in_store(qhash);
            end
        end
    end

    // Scoreboard monitor for reported matches.
    logic [IDXW-1:0] exp_q[$];
    always @(negedge clk) begin
        if (!rst && found_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_found: got index %0d, expected no report", found_index);
            end else begin
                check("found_index_sb", found_index, exp_q.pop_front());
            end
        end
    end

    // Strobe protocol monitor: pulse lengths, exclusivity, hash stability.
    int           nr_run = 0, cr_run = 0, nr_pulses = 0, cr_pulses = 0;
    logic [127:0] prev_hash = '0;
    bit           prev_act = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            nr_run   = 0;
            cr_run   = 0;
            prev_act = 1'b0;
        end else begin
            if (newrdy || checkrdy) check("strobe_overlap", newrdy & checkrdy, 0);
            if (newrdy || checkrdy || prev_act) check("hash_stable", hash, prev_hash);
            if (newrdy) nr_run++;
            else if (nr_run != 0) begin
                check("newrdy_len", nr_run, 2);
                nr_pulses++;
                nr_run = 0;
            end
            if (checkrdy) cr_run++;
            else if (cr_run != 0) begin
                check("checkrdy_len", cr_run, 2);
                cr_pulses++;
                cr_run = 0;
            end
            prev_act = newrdy || checkrdy;
        end
        prev_hash = hash;
    end

    task automatic send_tgt(input logic [127:0] h, input logic last);
        int n = 0;
        tgt_valid = 1'b1;
        tgt_hash  = h;
        tgt_last  = last;
        while (!tgt_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("tgt_ready_wait", n < 50, 1);
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        tgt_last  = 1'b0;
    endtask

    task automatic send_cand(input logic [127:0] h, input logic [IDXW-1:0] idx);
        int n = 0;
        while (!cand_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("cand_ready_wait", n < 50, 1);
        cand_valid = 1'b1;
        cand_hash  = h;
        cand_index = idx;
        @(posedge clk); #1;
        cand_valid = 1'b0;
    endtask

    int base;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_tgt_ready", tgt_ready, 1);
        check("rst_cand_ready", cand_ready, 0);
        check("rst_newrdy", newrdy, 0);
        check("rst_checkrdy", checkrdy, 0);
        check("rst_hash", hash, 0);
        check("rst_found_valid", found_valid, 0);
        check("rst_found_index", found_index, 0);
        check("rst_loaded_count", loaded_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout_err", timeout_err, 0);

        // Load three targets while a candidate is already offered.
        cand_valid = 1'b1;
        cand_hash  = T0;
        cand_index = 5;
        exp_q.push_back(5);
        send_tgt(T0, 1'b0);
        send_tgt(T1, 1'b0);
        check("no_query_in_load", cr_pulses, 0);
        check("cand_ready_in_load", cand_ready, 0);
        send_tgt(T2, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        check("load_cand_ready", cand_ready, 1);
        check("load_tgt_ready", tgt_ready, 0);
        check("load_count", loaded_count, 3);
        check("load_pulses", nr_pulses, 3);
        check("load_no_checkrdy", cr_pulses, 0);
        @(posedge clk); #1;
        cand_valid = 1'b0;
        check("held_cand_taken", cand_ready, 0);

        // No match, then match with exact latency.
        send_cand(C6, 6);
        repeat (5) begin @(posedge clk); #1; end
        check("nomatch_found_valid", found_valid, 0);
        check("nomatch_cand_ready", cand_ready, 1);
        check("found_index_held", found_index, 5);
        exp_q.push_back(7);
        send_cand(T2, 7);
        repeat (4) begin @(posedge clk); #1; end
        check("match_not_early", found_valid, 0);
        @(posedge clk); #1;
        check("match_found_valid", found_valid, 1);
        check("match_found_index", found_index, 7);
        check("match_cand_ready", cand_ready, 1);

        // Timeout: checker stays silent.
        mute = 1'b1;
        send_cand(T0, 9);
        repeat (10) begin @(posedge clk); #1; end
        check("timeout_not_early", timeout_err, 0);
        @(posedge clk); #1;
        check("timeout_err_set", timeout_err, 1);
        check("timeout_cand_ready", cand_ready, 1);
        check("timeout_no_found", found_valid, 0);
        mute = 1'b0;
        exp_q.push_back(10);
        send_cand(T1, 10);
        repeat (5) begin @(posedge clk); #1; end
        check("after_timeout_found", found_valid, 1);
        check("after_timeout_index", found_index, 10);

        // Reset while checkrdy is high.
        send_cand(T1, 11);
        @(posedge clk); #1;
        check("midq_checkrdy_high", checkrdy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midq_checkrdy_drop", checkrdy, 0);
        check("midq_hash_cleared", hash, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midq_tgt_ready", tgt_ready, 1);
        check("midq_cand_ready", cand_ready, 0);
        check("midq_count_cleared", loaded_count, 0);
        check("midq_timeout_cleared", timeout_err, 0);
        repeat (8) begin @(posedge clk); #1; end
        check("midq_tgt_ready_later", tgt_ready, 1);

        // Overflow: four targets with room for three.
        base = nr_pulses;
        send_tgt(HA, 1'b0);
        send_tgt(HB, 1'b0);
        send_tgt(HC, 1'b0);
        check("ovf_not_yet", overflow, 0);
        send_tgt(HD, 1'b1);
        check("ovf_set", overflow, 1);
        check("ovf_count", loaded_count, 3);
        check("ovf_pulses", nr_pulses - base, 3);
        check("ovf_cand_ready", cand_ready, 1);
        check("ovf_tgt_ready", tgt_ready, 0);
        send_cand(HD, 20);
        exp_q.push_back(21);
        send_cand(HA, 21);
        repeat (5) begin @(posedge clk); #1; end
        check("ovf_match_index", found_index, 21);

        repeat (4) begin @(posedge clk); #1; end
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_timeout_err", timeout_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
